ysyx_23060201_ifu: RTL

Instruction fetch unit for the single-issue, non-pipelined NPC core. Owns the architectural PC, fetches one 32-bit instruction per retired instruction over a valid/ready memory port, and hands the instruction plus its PC to decode and execute. Closes the loop by accepting `dnpc` from the execute stage. Faults on misaligned targets or memory errors by halting.

---
 rtl/ysyx_23060201_ifu_pkg.sv | 21 ++
 rtl/ysyx_23060201_ifu.sv | 95 +++++++++
 2 files changed

// File: rtl/ysyx_23060201_ifu_pkg.sv
// rtl/ysyx_23060201_ifu_pkg.sv - shared encodings for the instruction fetch unit
package ysyx_23060201_ifu_pkg;

  // Fetch FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    IFU_REQ  = 3'd0,
    IFU_WAIT = 3'd1,
    IFU_OUT  = 3'd2,
    IFU_NPC  = 3'd3,
    IFU_HALT = 3'd4
  } ifu_state_e;

  // Fault cause codes reported on fault_cause.
  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_MEMERR   = 2'd2;

  // Architectural PC after reset.
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060201_ifu.sv
// rtl/ysyx_23060201_ifu.sv - non-pipelined instruction fetch unit with fault halt
module ysyx_23060201_ifu
  import ysyx_23060201_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        dnpc_valid,
  input  logic [31:0] dnpc,
  output logic        halted,
  output logic [1:0]  fault_cause,
  output logic [31:0] fetch_count
);

  ifu_state_e  state;
  ifu_state_e  state_next;
  logic [31:0] pc;

  // Outputs decode straight from registers so no input reaches an output combinationally.
  assign imem_req_valid = (state == IFU_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == IFU_OUT);
  assign halted         = (state == IFU_HALT);

  // Next-state logic; HALT is absorbing and only reset leaves it.
  always_comb begin
    state_next = state;
    case (state)
      IFU_REQ:  if (imem_req_ready) state_next = IFU_WAIT;
      IFU_WAIT: if (imem_rsp_valid) state_next = imem_rsp_err ? IFU_HALT : IFU_OUT;
      IFU_OUT:  if (inst_ready) state_next = IFU_NPC;
      IFU_NPC:  if (dnpc_valid) state_next = (dnpc[1:0] != 2'b00) ? IFU_HALT : IFU_REQ;
      IFU_HALT: state_next = IFU_HALT;
      default:  state_next = IFU_HALT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IFU_REQ;
    end else begin
      state <= state_next;
    end
  end

  // PC, instruction latch, fault cause and retire counter; reset beats any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inst        <= 32'd0;
      inst_pc     <= 32'd0;
      fault_cause <= FAULT_NONE;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        IFU_WAIT: begin
          if (imem_rsp_valid) begin
            if (imem_rsp_err) begin
              fault_cause <= FAULT_MEMERR;
            end else begin
              inst    <= imem_rsp_data;
              inst_pc <= pc;
            end
          end
        end
        IFU_OUT: begin
          if (inst_ready) fetch_count <= fetch_count + 32'd1;
        end
        IFU_NPC: begin
          if (dnpc_valid) begin
            if (dnpc[1:0] != 2'b00) begin
              fault_cause <= FAULT_MISALIGN;
            end else begin
              pc <= dnpc;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
